alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execution stage directly downstream of the ALU control decoder in the MIPS datapath. Consumes the 4-bit ALU control code plus two operands.
- ADD, SUB, AND, OR and SLT complete in one cycle.
- DIV runs as an iterative signed restoring divider over WIDTH cycles. While it runs, `busy` is high so the controller can stall the PC and register-file write.
- Results are registered and qualified by a one-cycle `done` pulse.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue strobe; sampled only when busy=0
- alu_control  input  4  operation code from the decoder
- a  input  WIDTH  operand A / dividend (two's complement)
- b  input  WIDTH  operand B / divisor (two's complement)
- result  output  WIDTH  registered result / quotient
- remainder  output  WIDTH  DIV remainder; 0 for non-DIV ops
- zero  output  1  registered (result == 0)
- done  output  1  one-cycle pulse: result, remainder, zero, div_by_zero valid
- busy  output  1  high while a DIV is in flight
- div_by_zero  output  1  registered flag; set by DIV with b == 0

Behaviour:
- Interface:
  - One clock `clk`. Reset `rst_n` is asynchronous and active-low.
  - rst_n low forces all outputs to 0 and the FSM to IDLE, including mid-DIV. The in-flight operation is discarded and no done is produced.
- Operation codes (alu_control):
  - 0010 ADD, wrap modulo 2^WIDTH
  - 0110 SUB, a−b wrap
  - 0000 AND
  - 0001 OR
  - 0111 SLT, signed; result 1 or 0
  - 0101 DIV, signed
  - Any other code: illegal; result=0, remainder=0, zero=1, done pulses in 1 cycle.
- FSM states: IDLE, DIV, FIX.
  - **IDLE:**
    - At the edge where start=1, a single-cycle op registers result/zero, clears remainder and div_by_zero, and pulses done in the next cycle (latency 1). The FSM stays in IDLE.
    - start=0 leaves all outputs held. done=0.
  - **IDLE + DIV with b ≠ 0:**
    - Load |a| and |b| into internal registers. Latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB].
    - Clear the partial remainder; count = WIDTH−1; go to DIV; busy=1.
  - **IDLE + DIV with b = 0:**
    - No iteration. result = all ones, remainder = a, div_by_zero=1, zero=0.
    - done in 1 cycle; busy stays 0.
  - **DIV:**
    - One quotient bit per edge: shift {rem,quo} left, trial-subtract |b|, keep if non-negative.
    - When count==0 go to FIX; otherwise decrement count.
  - **FIX:**
    - Negate the quotient if sign_q; negate the remainder if sign_r.
    - Register result, remainder and zero; clear div_by_zero; pulse done; return to IDLE with busy=0.
- DIV timing:
  - start sampled at edge E0; iterations on E1..E_WIDTH; FIX at E_(WIDTH+1).
  - done is high for exactly one cycle after E_(WIDTH+1). busy is high from after E0 until after E_(WIDTH+1).
- Boundary cases:
  - start while busy=1 is ignored, and operands/opcode changes are ignored; the in-flight DIV is unaffected.
  - start asserted in the cycle done is high is accepted, since busy is already 0.
  - −2^(WIDTH−1) / −1 gives quotient 0x80..0, remainder 0 (natural wrap; no trap).
  - Quotient truncates toward zero. The remainder carries the dividend's sign, or is 0.
  - result, remainder, zero and div_by_zero hold their values between done pulses.

Optional Feature:
- Macro ALU_DIVU_EN.
- Defined: code 1101 performs unsigned DIVU. Same FSM and timing as DIV, no sign conversion or FIX negation; b=0 behaves as DIV with b=0.
- Undefined: 1101 is an illegal code (result 0, done in 1 cycle); no unsigned datapath is synthesised.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle → all outputs 0 immediately, busy=0.
- ADD 0x7FFFFFFF + 1, start 1 cycle → result 0x80000000, zero=0, done 1 cycle later. SUB 5−5 → result 0, zero=1.
- SLT a=0xFFFFFFFF (−1), b=1 → result 1. AND/OR 0xF0F0F0F0, 0x0FF00FF0 → 0x00F000F0 / 0xFFF0FFF0.
- DIV −7/2 → busy for 33 cycles, done after E33, result 0xFFFFFFFD, remainder 0xFFFFFFFF. Re-issuing start with a new op while busy changes nothing.
- DIV 100/0 → done after 1 cycle, div_by_zero=1, result 0xFFFFFFFF, remainder 100. DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000, remainder 0.
- rst_n pulsed at iteration 10 of a DIV → no done pulse, busy=0. A following ADD 2+3 gives 5 with 1-cycle latency. With ALU_DIVU_EN: DIVU 0xFFFFFFFE/2 → 0x7FFFFFFF, remainder 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// MIPS execution stage: one-cycle ADD/SUB/AND/OR/SLT and a WIDTH-cycle signed restoring divider.
// Optional build macro ALU_DIVU_EN adds unsigned DIVU on code 4'b1101.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
`ifdef ALU_DIVU_EN
  localparam logic [3:0] OP_DIVU = 4'b1101;
`endif

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_DIV  = 2'b01;
  localparam logic [1:0] S_FIX  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;

  logic [WIDTH-1:0] single_res;
  logic             is_div_op, is_signed_div;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   trial_sh, trial_diff;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Single-cycle ops; illegal codes fall through to a zero result.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    single_res = '0;
    case (alu_control)
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: single_res = '0;
    endcase
  end

  always_comb begin
    is_div_op     = 1'b0;
    is_signed_div = 1'b0;
    if (alu_control == OP_DIV) begin
      is_div_op     = 1'b1;
      is_signed_div = 1'b1;
    end
`ifdef ALU_DIVU_EN
    else if (alu_control == OP_DIVU) begin
      is_div_op = 1'b1;
    end
`endif
  end

  // Magnitudes; -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
  assign abs_a = (is_signed_div && a[WIDTH-1]) ? -a : a;
  assign abs_b = (is_signed_div && b[WIDTH-1]) ? -b : b;

  // One extra bit keeps 2*rem+1 from overflowing when the divisor uses the full width.
  assign trial_sh   = {prem_q, quo_q[WIDTH-1]};
  assign trial_diff = trial_sh - {1'b0, dvsr_q};

  assign quo_fix = sign_q_q ? -quo_q  : quo_q;
  assign rem_fix = sign_r_q ? -prem_q : prem_q;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    rem_out_d = rem_out_q;
    zero_d    = zero_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    quo_d     = quo_q;
    prem_d    = prem_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    sign_q_d  = sign_q_q;
    sign_r_d  = sign_r_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_div_op) begin
            if (b == '0) begin
              result_d  = '1;
              rem_out_d = a;
              zero_d    = 1'b0;
              dbz_d     = 1'b1;
              done_d    = 1'b1;
            end else begin
              quo_d    = abs_a;
              dvsr_d   = abs_b;
              prem_d   = '0;
              sign_q_d = is_signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
              sign_r_d = is_signed_div & a[WIDTH-1];
              cnt_d    = CNT_W'(WIDTH - 1);
              state_d  = S_DIV;
            end
          end else begin
            result_d  = single_res;
            rem_out_d = '0;
            zero_d    = (single_res == '0);
            dbz_d     = 1'b0;
            done_d    = 1'b1;
          end
        end
      end

      S_DIV: begin
        if (!trial_diff[WIDTH]) begin
          prem_d = trial_diff[WIDTH-1:0];
          quo_d  = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = trial_sh[WIDTH-1:0];
          quo_d  = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FIX: begin
        result_d  = quo_fix;
        rem_out_d = rem_fix;
        zero_d    = (quo_fix == '0);
        dbz_d     = 1'b0;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      rem_out_q <= '0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      quo_q     <= '0;
      prem_q    <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q   <= state_d;
      result_q  <= result_d;
      rem_out_q <= rem_out_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      quo_q     <= quo_d;
      prem_q    <= prem_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      sign_q_q  <= sign_q_d;
      sign_r_q  <= sign_r_d;
    end
  end

  assign result      = result_q;
  assign remainder   = rem_out_q;
  assign zero        = zero_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed test-plan steps plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   alu_control;
  logic [W-1:0] a, b;
  logic [W-1:0] result, remainder;
  logic         zero, done, busy, div_by_zero;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .result      (result),
    .remainder   (remainder),
    .zero        (zero),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: done_at is the count of falling edges after the issuing edge at which done is seen.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [W-1:0] rm,
                                output logic z, output logic dz, output int done_at);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0; rm = '0; dz = 1'b0; done_at = 1;
    case (op)
      OP_ADD: r = x + y;
      OP_SUB: r = x - y;
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_SLT: r = (sx < sy) ? 1 : 0;
      OP_DIV: begin
        if (y == 0) begin r = '1; rm = x; dz = 1'b1; end
        else begin r = W'(sx / sy); rm = W'(sx % sy); done_at = W + 2; end
      end
`ifdef ALU_DIVU_EN
      OP_DIVU: begin
        if (y == 0) begin r = '1; rm = x; dz = 1'b1; end
        else begin r = x / y; rm = x % y; done_at = W + 2; end
      end
`endif
      default: r = '0;
    endcase
    z = (r == '0);
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] opa,
                        input logic [W-1:0] opb, input bit poke);
    logic [W-1:0] er, erm;
    logic         ez, edz;
    int           edone, cyc, bcnt;
    model(op, opa, opb, er, erm, ez, edz, edone);
    @(negedge clk);
    start = 1'b1; alu_control = op; a = opa; b = opb;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; bcnt = 0;
    while (!done && cyc < 200) begin
      if (busy) bcnt++;
      if (poke && cyc == 5) begin
        start = 1'b1; alu_control = OP_OR; a = $urandom; b = $urandom;
      end
      if (poke && cyc == 6) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, " done_cycle"}, 64'(cyc), 64'(edone));
    check({tag, " busy_cycles"}, 64'(bcnt), 64'(edone - 1));
    check({tag, " result"}, 64'(result), 64'(er));
    check({tag, " remainder"}, 64'(remainder), 64'(erm));
    check({tag, " zero"}, 64'(zero), 64'(ez));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
    check({tag, " busy_at_done"}, 64'(busy), 64'(0));
    @(negedge clk);
    check({tag, " done_pulse_len"}, 64'(done), 64'(0));
    check({tag, " result_held"}, 64'(result), 64'(er));
  endtask

  initial begin
    logic [3:0]   ops [9];
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    int           dcnt;

    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_DIV, OP_DIVU, 4'b0011, 4'b1111};
    rst_n = 1'b1; start = 1'b0; alu_control = '0; a = '0; b = '0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst result", 64'(result), 64'(0));
    check("rst remainder", 64'(remainder), 64'(0));
    check("rst flags", 64'({zero, done, busy, div_by_zero}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0);
    check("add_ovf const", 64'(result), 64'h8000_0000);
    run_op("sub_eq", OP_SUB, 32'd5, 32'd5, 1'b0);
    check("sub_eq zero const", 64'(zero), 64'(1));
    run_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'h1, 1'b0);
    check("slt_neg const", 64'(result), 64'(1));
    run_op("and", OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    check("and const", 64'(result), 64'h00F0_00F0);
    run_op("or", OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
    check("or const", 64'(result), 64'hFFF0_FFF0);
    run_op("illegal", 4'b1111, 32'h1234, 32'h5678, 1'b0);

    // start during the done cycle is accepted
    @(negedge clk);
    start = 1'b1; alu_control = OP_ADD; a = 32'd7; b = 32'd8;
    @(negedge clk);
    check("b2b first done", 64'(done), 64'(1));
    check("b2b first result", 64'(result), 64'(15));
    alu_control = OP_SUB;
    @(negedge clk);
    check("b2b second done", 64'(done), 64'(1));
    check("b2b second result", 64'(result), 64'hFFFF_FFFF);
    start = 1'b0;
    @(negedge clk);
    check("b2b done low", 64'(done), 64'(0));

    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    check("div_m7_2 quo const", 64'(result), 64'hFFFF_FFFD);
    check("div_m7_2 rem const", 64'(remainder), 64'hFFFF_FFFF);
    run_op("div_by0", OP_DIV, 32'd100, 32'd0, 1'b0);
    check("div_by0 rem const", 64'(remainder), 64'(100));
    run_op("div_minint", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_minint const", 64'(result), 64'h8000_0000);
    run_op("div_by0_again", OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);

    // Reset in the middle of a DIV discards it
    @(negedge clk);
    start = 1'b1; alu_control = OP_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("middiv busy before rst", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("middiv rst busy", 64'(busy), 64'(0));
    check("middiv rst result", 64'(result), 64'(0));
    check("middiv rst remainder", 64'(remainder), 64'(0));
    check("middiv rst flags", 64'({zero, done, div_by_zero}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("middiv no done", 64'(dcnt), 64'(0));
    run_op("add_after_rst", OP_ADD, 32'd2, 32'd3, 1'b0);

`ifdef ALU_DIVU_EN
    run_op("divu", OP_DIVU, 32'hFFFF_FFFE, 32'd2, 1'b0);
    check("divu const", 64'(result), 64'h7FFF_FFFF);
`else
    run_op("divu_illegal", OP_DIVU, 32'hFFFF_FFFE, 32'd2, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(0, 8)];
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = ($urandom_range(0, 1) == 1) ? -W'($urandom_range(1, 15)) : W'($urandom_range(1, 15));
        2: rb = '0;
        default: rb = ra;
      endcase
      run_op("random", rop, ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
